// File: rtl/ita_ctrl_context_queue_if.sv
// ----------------------------------------------------------------------------
// ita_ctrl_context_queue_if
//   Register-port bundle between the HWPE host side and the context queue.
//   master : host that issues requests (drives req/we/addr/wdata)
//   slave  : context queue (drives gnt/rvalid/rdata)
//   Signals:
//     cfg_req    request
//     cfg_we     1 = write, 0 = read
//     cfg_addr   register index (<0x80) or command (0x80..0x83)
//     cfg_wdata  write data
//     cfg_gnt    grant, combinational copy of cfg_req
//     cfg_rvalid read data valid, one cycle after a granted read
//     cfg_rdata  registered read data
// ----------------------------------------------------------------------------
interface ita_ctrl_context_queue_if;
    logic        cfg_req;
    logic        cfg_we;
    logic [7:0]  cfg_addr;
    logic [31:0] cfg_wdata;
    logic        cfg_gnt;
    logic        cfg_rvalid;
    logic [31:0] cfg_rdata;

    modport master (
        output cfg_req, cfg_we, cfg_addr, cfg_wdata,
        input  cfg_gnt, cfg_rvalid, cfg_rdata
    );

    modport slave (
        input  cfg_req, cfg_we, cfg_addr, cfg_wdata,
        output cfg_gnt, cfg_rvalid, cfg_rdata
    );
endinterface

// File: rtl/ita_ctrl_context_queue.sv
// ----------------------------------------------------------------------------
// ita_ctrl_context_queue
//   Multi-context job queue between the HWPE register port and the ITA engine.
//   The host fills the slot at wptr, commits it with TRIGGER (0x80); committed
//   jobs are dispatched to the engine in FIFO order from rptr, and each engine
//   completion raises a one-cycle done event carrying the slot id.
//   Commands: 0x80 TRIGGER (wr), 0x81 ACQUIRE (rd), 0x82 STATUS (rd),
//             0x83 SOFT_CLEAR (wr).
//   Ports:
//     clk_i, rst_ni   clock, synchronous active-low reset
//     cfg             register port (slave modport)
//     job_valid_o     dispatched context valid
//     job_ready_i     engine accepts context
//     job_regs_o      register image of slot rptr (reg i at [32*i +: 32])
//     job_id_o        slot id of the dispatched/running job
//     eng_done_i      engine finished running job (1-cycle pulse)
//     evt_done_o      per-job done event (1-cycle pulse)
//     evt_id_o        slot id of the completed job
//     busy_o          FSM not idle, or jobs still queued
// ----------------------------------------------------------------------------
module ita_ctrl_context_queue #(
    parameter int unsigned N_CONTEXT = 2,
    parameter int unsigned N_REGS    = 17,
    parameter int unsigned ID_WIDTH  = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    ita_ctrl_context_queue_if.slave  cfg,
    output logic                     job_valid_o,
    input  logic                     job_ready_i,
    output logic [N_REGS*32-1:0]     job_regs_o,
    output logic [ID_WIDTH-1:0]      job_id_o,
    input  logic                     eng_done_i,
    output logic                     evt_done_o,
    output logic [ID_WIDTH-1:0]      evt_id_o,
    output logic                     busy_o
);

    localparam logic [7:0] ADDR_TRIGGER    = 8'h80;
    localparam logic [7:0] ADDR_ACQUIRE    = 8'h81;
    localparam logic [7:0] ADDR_STATUS     = 8'h82;
    localparam logic [7:0] ADDR_SOFT_CLEAR = 8'h83;

    localparam logic [4:0]          N_CTX    = 5'(N_CONTEXT);
    localparam logic [ID_WIDTH-1:0] LAST_PTR = ID_WIDTH'(N_CONTEXT - 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DISPATCH,
        ST_RUNNING,
        ST_DONE
    } state_e;

    state_e              state_q, state_d;
    logic [4:0]          count_q, count_d;
    logic [ID_WIDTH-1:0] wptr_q, wptr_d;
    logic [ID_WIDTH-1:0] rptr_q, rptr_d;
    logic                overflow_q, overflow_d;
    logic                rvalid_q;
    logic [31:0]         rdata_q, rdata_d;

    // Slot storage is deliberately not reset.
    logic [31:0]         slot_q [N_CONTEXT][N_REGS];

    logic wr_en, rd_en, reg_hit;
    logic trigger, soft_clear, done_fire, full, push;

    assign wr_en      = cfg.cfg_req & cfg.cfg_we;
    assign rd_en      = cfg.cfg_req & ~cfg.cfg_we;
    assign reg_hit    = (cfg.cfg_addr < 8'(N_REGS));
    assign trigger    = wr_en && (cfg.cfg_addr == ADDR_TRIGGER);
    assign soft_clear = wr_en && (cfg.cfg_addr == ADDR_SOFT_CLEAR);
    assign done_fire  = (state_q == ST_DONE);
    assign full       = (count_q >= N_CTX);
    // A trigger on a full queue still commits when Done frees a slot on the same edge.
    assign push       = trigger && (!full || done_fire);

    assign cfg.cfg_gnt    = cfg.cfg_req;
    assign cfg.cfg_rvalid = rvalid_q;
    assign cfg.cfg_rdata  = rdata_q;

    function automatic logic [ID_WIDTH-1:0] ptr_inc(input logic [ID_WIDTH-1:0] p);
        if (p == LAST_PTR) begin
            return '0;
        end
        return p + ID_WIDTH'(1);
    endfunction

    // ------------------------------------------------------------------
    // Queue bookkeeping: count, pointers, sticky overflow
    // ------------------------------------------------------------------
    always_comb begin
        count_d    = count_q;
        wptr_d     = wptr_q;
        rptr_d     = rptr_q;
        overflow_d = overflow_q;
        if (soft_clear) begin
            count_d    = '0;
            wptr_d     = '0;
            rptr_d     = '0;
            overflow_d = 1'b0;
        end else begin
            if (push) begin
                wptr_d = ptr_inc(wptr_q);
            end
            if (trigger && !push) begin
                overflow_d = 1'b1;
            end
            if (done_fire) begin
                rptr_d = ptr_inc(rptr_q);
            end
            unique case ({push, done_fire})
                2'b10:   count_d = count_q + 5'd1;
                2'b01:   count_d = count_q - 5'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Dispatch FSM: next state and state-decoded outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        job_valid_o = 1'b0;
        job_id_o    = '0;
        evt_done_o  = 1'b0;
        evt_id_o    = '0;
        busy_o      = (state_q != ST_IDLE) || (count_q != '0);
        unique case (state_q)
            ST_IDLE: begin
                if (count_q != '0) begin
                    state_d = ST_DISPATCH;
                end
            end
            ST_DISPATCH: begin
                job_valid_o = 1'b1;
                job_id_o    = rptr_q;
                if (job_ready_i) begin
                    state_d = ST_RUNNING;
                end
            end
            ST_RUNNING: begin
                job_id_o = rptr_q;
                if (eng_done_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                evt_done_o = 1'b1;
                evt_id_o   = rptr_q;
                state_d    = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (soft_clear) begin
            state_d = ST_IDLE;
        end
    end

    // Register image of the dispatched/running slot; zero while idle.
    always_comb begin
        job_regs_o = '0;
        if ((state_q == ST_DISPATCH) || (state_q == ST_RUNNING)) begin
            for (int unsigned c = 0; c < N_CONTEXT; c++) begin
                if (rptr_q == ID_WIDTH'(c)) begin
                    for (int unsigned r = 0; r < N_REGS; r++) begin
                        job_regs_o[32*r +: 32] = slot_q[c][r];
                    end
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Read mux (registered into rdata_q)
    // ------------------------------------------------------------------
    always_comb begin
        rdata_d = '0;
        if (reg_hit) begin
            for (int unsigned c = 0; c < N_CONTEXT; c++) begin
                for (int unsigned r = 0; r < N_REGS; r++) begin
                    if ((wptr_q == ID_WIDTH'(c)) && (cfg.cfg_addr == 8'(r))) begin
                        rdata_d = slot_q[c][r];
                    end
                end
            end
        end else begin
            unique case (cfg.cfg_addr)
                ADDR_ACQUIRE: rdata_d = full ? '1 : 32'(wptr_q);
                ADDR_STATUS:  rdata_d = {16'h0000, 4'(wptr_q), 4'(rptr_q),
                                         2'b00, overflow_q, busy_o, count_q[3:0]};
                default:      rdata_d = '0;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q    <= ST_IDLE;
            count_q    <= '0;
            wptr_q     <= '0;
            rptr_q     <= '0;
            overflow_q <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            count_q    <= count_d;
            wptr_q     <= wptr_d;
            rptr_q     <= rptr_d;
            overflow_q <= overflow_d;
            rvalid_q   <= rd_en;
            if (soft_clear) begin
                rdata_q <= '0;
            end else if (rd_en) begin
                rdata_q <= rdata_d;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_ni && wr_en && reg_hit) begin
            for (int unsigned c = 0; c < N_CONTEXT; c++) begin
                for (int unsigned r = 0; r < N_REGS; r++) begin
                    if ((wptr_q == ID_WIDTH'(c)) && (cfg.cfg_addr == 8'(r))) begin
                        slot_q[c][r] <= cfg.cfg_wdata;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_ita_ctrl_context_queue.sv
// ----------------------------------------------------------------------------
// tb_ita_ctrl_context_queue
//   Directed stimulus for the context queue. Stimulus pushes expected read
//   data, dispatches and done events into queues; a negedge monitor pops and
//   compares whenever the DUT presents rvalid, a rising job_valid_o or
//   evt_done_o.
// ----------------------------------------------------------------------------
module tb_ita_ctrl_context_queue;
    localparam int unsigned N_CONTEXT = 2;
    localparam int unsigned N_REGS    = 17;
    localparam int unsigned ID_WIDTH  = 2;

    typedef struct {
        logic [31:0] data;
        string       name;
    } rd_exp_t;

    typedef struct {
        logic [ID_WIDTH-1:0] id;
        int                  cyc;
    } evt_exp_t;

    // cyc < 0: dispatch cycle not checked; b2b: expected two cycles after last done event
    typedef struct {
        logic [ID_WIDTH-1:0] id;
        logic [31:0]         reg5;
        int                  cyc;
        bit                  b2b;
    } job_exp_t;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic                 job_valid;
    logic                 job_ready = 1'b0;
    logic [N_REGS*32-1:0] job_regs;
    logic [ID_WIDTH-1:0]  job_id;
    logic                 eng_done = 1'b0;
    logic                 evt_done;
    logic [ID_WIDTH-1:0]  evt_id;
    logic                 busy;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    rd_exp_t  exp_rd[$];
    evt_exp_t exp_evt[$];
    job_exp_t exp_job[$];

    ita_ctrl_context_queue_if cfg ();

    ita_ctrl_context_queue #(
        .N_CONTEXT (N_CONTEXT),
        .N_REGS    (N_REGS),
        .ID_WIDTH  (ID_WIDTH)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .cfg         (cfg),
        .job_valid_o (job_valid),
        .job_ready_i (job_ready),
        .job_regs_o  (job_regs),
        .job_id_o    (job_id),
        .eng_done_i  (eng_done),
        .evt_done_o  (evt_done),
        .evt_id_o    (evt_id),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual 0x%08h required 0x%08h", name, act, exp);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    logic job_valid_prev = 1'b0;
    int   last_evt_cyc = 0;

    always @(negedge clk) begin
        rd_exp_t  r;
        evt_exp_t e;
        job_exp_t j;
        if (cfg.cfg_rvalid === 1'b1) begin
            if (exp_rd.size() == 0) begin
                checks++; errors++;
                $display("FAIL rd_unexpected: actual rdata 0x%08h required no read response", cfg.cfg_rdata);
            end else begin
                r = exp_rd.pop_front();
                check(r.name, cfg.cfg_rdata, r.data);
            end
        end
        if (evt_done === 1'b1) begin
            if (exp_evt.size() == 0) begin
                checks++; errors++;
                $display("FAIL evt_unexpected: actual evt_done_o=1 id %0d required no event", evt_id);
            end else begin
                e = exp_evt.pop_front();
                check("evt_id", 32'(evt_id), 32'(e.id));
                check("evt_cycle", 32'(cyc), 32'(e.cyc));
            end
            last_evt_cyc = cyc;
        end
        if (job_valid === 1'b1 && job_valid_prev !== 1'b1) begin
            if (exp_job.size() == 0) begin
                checks++; errors++;
                $display("FAIL job_unexpected: actual job_valid_o=1 id %0d required no dispatch", job_id);
            end else begin
                j = exp_job.pop_front();
                check("job_id", 32'(job_id), 32'(j.id));
                check("job_reg5", job_regs[5*32 +: 32], j.reg5);
                if (j.b2b)
                    check("job_b2b_cycle", 32'(cyc), 32'(last_evt_cyc + 2));
                else if (j.cyc >= 0)
                    check("job_cycle", 32'(cyc), 32'(j.cyc));
            end
        end
        job_valid_prev = job_valid;
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step();
    endtask

    task automatic cfg_write(input logic [7:0] a, input logic [31:0] d);
        cfg.cfg_req   = 1'b1;
        cfg.cfg_we    = 1'b1;
        cfg.cfg_addr  = a;
        cfg.cfg_wdata = d;
        #1;
        check("cfg_gnt", 32'(cfg.cfg_gnt), 32'd1);
        step();
        cfg.cfg_req = 1'b0;
        cfg.cfg_we  = 1'b0;
    endtask

    task automatic cfg_read(input logic [7:0] a, input logic [31:0] exp, input string name);
        exp_rd.push_back('{data: exp, name: name});
        cfg.cfg_req  = 1'b1;
        cfg.cfg_we   = 1'b0;
        cfg.cfg_addr = a;
        step();
        cfg.cfg_req = 1'b0;
    endtask

    task automatic trigger(input bit expect_job, input logic [ID_WIDTH-1:0] eid,
                           input logic [31:0] ereg5, input bit timed, input bit b2b);
        if (expect_job)
            exp_job.push_back('{id: eid, reg5: ereg5, cyc: (timed ? cyc + 2 : -1), b2b: b2b});
        cfg_write(8'h80, 32'h0);
    endtask

    task automatic wait_job(input int max_cyc);
        int n = 0;
        while (job_valid !== 1'b1 && n < max_cyc) begin
            step();
            n++;
        end
        check("wait_job_valid", 32'(job_valid), 32'd1);
    endtask

    // Expects job_ready high; returns in the Done cycle.
    task automatic run_job(input logic [ID_WIDTH-1:0] eid);
        wait_job(20);
        step();
        eng_done = 1'b1;
        exp_evt.push_back('{id: eid, cyc: cyc + 1});
        step();
        eng_done = 1'b0;
    endtask

    task automatic pulse_done();
        eng_done = 1'b1;
        step();
        eng_done = 1'b0;
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_job_valid"}, 32'(job_valid), 32'd0);
        check({tag, "_evt_done"}, 32'(evt_done), 32'd0);
        check({tag, "_busy"}, 32'(busy), 32'd0);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        cfg.cfg_req   = 1'b0;
        cfg.cfg_we    = 1'b0;
        cfg.cfg_addr  = 8'h00;
        cfg.cfg_wdata = 32'h0;

        // 1. reset state
        idle(3);
        check_quiet("reset");
        check("reset_rvalid", 32'(cfg.cfg_rvalid), 32'd0);
        check("reset_rdata", cfg.cfg_rdata, 32'h0);
        check("reset_job_id", 32'(job_id), 32'd0);
        check("reset_evt_id", 32'(evt_id), 32'd0);
        check("reset_job_regs_nonzero", 32'(job_regs != '0), 32'd0);
        rst_n = 1'b1;
        idle(1);
        cfg_read(8'h82, 32'h0000_0000, "status_reset");
        cfg_read(8'h81, 32'h0000_0000, "acquire_reset");
        cfg_write(8'h20, 32'hDEAD_BEEF);
        cfg_read(8'h20, 32'h0000_0000, "unused_reg_read");

        // 2. single job, timed dispatch and done
        job_ready = 1'b1;
        cfg_write(8'd5, 32'h0000_0040);
        cfg_write(8'd13, 32'h0000_0001);
        cfg_read(8'd5, 32'h0000_0040, "reg5_readback");
        trigger(1'b1, 2'd0, 32'h0000_0040, 1'b1, 1'b0);
        wait_job(10);
        check("job_reg13", job_regs[13*32 +: 32], 32'h0000_0001);
        step();
        eng_done = 1'b1;
        exp_evt.push_back('{id: 2'd0, cyc: cyc + 1});
        step();
        eng_done = 1'b0;
        idle(1);
        cfg_read(8'h82, 32'h0000_1100, "status_after_job0");
        pulse_done();   // outside Running: no event expected
        idle(2);

        // 3. fill to full and overflow
        cfg_write(8'h83, 32'h0);
        cfg_read(8'h82, 32'h0000_0000, "status_after_clear");
        job_ready = 1'b0;
        cfg_write(8'd5, 32'h0000_00A0);
        trigger(1'b1, 2'd0, 32'h0000_00A0, 1'b0, 1'b0);
        cfg_read(8'h81, 32'h0000_0001, "acquire_one_free");
        cfg_write(8'd5, 32'h0000_00A1);
        trigger(1'b1, 2'd1, 32'h0000_00A1, 1'b0, 1'b1);
        trigger(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
        cfg_read(8'h82, 32'h0000_0032, "status_full_overflow");
        cfg_read(8'h81, 32'hFFFF_FFFF, "acquire_full");

        // 4. in-order completion with wrap
        job_ready = 1'b1;
        run_job(2'd0);
        idle(1);
        cfg_read(8'h82, 32'h0000_0131, "status_count1");
        run_job(2'd1);
        idle(1);
        cfg_read(8'h82, 32'h0000_0020, "status_drained");

        // 5. trigger on the Done edge of a full queue
        cfg_write(8'h83, 32'h0);
        cfg_read(8'h82, 32'h0000_0000, "status_clear2");
        job_ready = 1'b0;
        cfg_write(8'd5, 32'h0000_00C0);
        trigger(1'b1, 2'd0, 32'h0000_00C0, 1'b0, 1'b0);
        cfg_write(8'd5, 32'h0000_00C1);
        trigger(1'b1, 2'd1, 32'h0000_00C1, 1'b0, 1'b1);
        job_ready = 1'b1;
        run_job(2'd0);
        trigger(1'b1, 2'd0, 32'h0000_00C0, 1'b0, 1'b1);
        cfg_read(8'h82, 32'h0000_1112, "status_done_trigger");
        run_job(2'd1);
        run_job(2'd0);
        idle(1);
        cfg_read(8'h82, 32'h0000_1100, "status_after_three");

        // 6a. soft clear while Running
        cfg_write(8'h83, 32'h0);
        cfg_read(8'h82, 32'h0000_0000, "status_clear3");
        trigger(1'b1, 2'd0, 32'h0000_00C0, 1'b0, 1'b0);
        wait_job(10);
        step();
        cfg_write(8'h83, 32'h0);
        check_quiet("clear_running");
        pulse_done();
        cfg_read(8'h82, 32'h0000_0000, "status_clear_running");
        idle(2);
        check("clear_running_job_valid_late", 32'(job_valid), 32'd0);

        // 6b. reset mid-Dispatch
        job_ready = 1'b0;
        trigger(1'b1, 2'd0, 32'h0000_00C0, 1'b0, 1'b0);
        wait_job(10);
        rst_n = 1'b0;
        step();
        check_quiet("rst_dispatch");
        rst_n = 1'b1;
        pulse_done();
        cfg_read(8'h82, 32'h0000_0000, "status_rst_dispatch");
        cfg_read(8'd5, 32'h0000_00C0, "slot_kept_over_reset");
        idle(3);
        check("rst_dispatch_job_valid_late", 32'(job_valid), 32'd0);

        check("scoreboard_drained", 32'(exp_rd.size() + exp_evt.size() + exp_job.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
